// File: rtl/instr_encoder.sv
// RV32I subset encoder: turns micro-op fields into instruction words and
// streams them through a small FIFO with sequential byte addresses.
module instr_encoder #(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [19:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);
  localparam int PW = $clog2(DEPTH);

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_S  = 7'b0100011;
  localparam logic [6:0] OPC_L  = 7'b0000011;
  localparam logic [6:0] OPC_U  = 7'b0110111;

  logic [31:0]       mem_q [DEPTH];
  logic [PW:0]       wr_q, rd_q, wr_d, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [31:0]       enc;
  logic              legal, full, empty, accept, push, pop;

  always_comb begin
    enc   = '0;
    legal = 1'b1;
    case (in_op)
      4'd0: enc = {7'b0, in_rs2, in_rs1, 3'b000, in_rd, OPC_R};
      4'd1: enc = {7'b0, in_rs2, in_rs1, 3'b100, in_rd, OPC_R};
      4'd2: enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_I};
      4'd3: enc = {in_imm[11:0], in_rs1, 3'b110, in_rd, OPC_I};
      4'd4: enc = {7'b0100000, in_imm[4:0], in_rs1, 3'b101, in_rd, OPC_I};
      4'd5: enc = {in_imm[11:5], in_rs2, in_rs1, 3'b000, in_imm[4:0], OPC_S};
      4'd6: enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OPC_S};
      4'd7: enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_L};
      4'd8: enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, OPC_L};
      4'd9: enc = {in_imm[19:0], in_rd, OPC_U};
      default: legal = 1'b0;
    endcase
  end

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign accept = in_valid & ~full;
  assign push   = accept & legal & ~flush;
  assign pop    = ~empty & out_ready & ~flush;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    addr_d = addr_q;
    err_d  = err_q | (accept & ~legal);
    if (flush) begin
      wr_d   = '0;
      rd_d   = '0;
      addr_d = BASE_ADDR;
    end else begin
      if (push) wr_d = wr_q + 1'b1;
      if (pop) begin
        rd_d   = rd_q + 1'b1;
        addr_d = addr_q + ADDR_W'(4);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[PW-1:0]] <= enc;
  end

  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign out_instr = empty ? 32'h0 : mem_q[rd_q[PW-1:0]];
  assign out_addr  = addr_q;
  assign err       = err_q;
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the main decoder: encodes a compact micro-op command stream into RV32I instruction words for the supported subset: ADD, XOR, ADDI, ORI, SRAI, SB, SW, LB, LW, LUI. Encoded words are buffered in a small FIFO and streamed to the instruction-memory loader with sequential word addresses. It sits between the bench/boot program source and instruction memory, so that decoder-level test programs can be built from fields rather than hand-assembled hex.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- ADDR_W, 32: width of `out_addr`.
- BASE_ADDR, 0: address of the first emitted word.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of FIFO and address counter.
- in_valid  in  1  command present.
- in_ready  out  1  command accepted when `in_valid & in_ready`.
- in_op  in  4  operation select: 0 ADD, 1 XOR, 2 ADDI, 3 ORI, 4 SRAI, 5 SB, 6 SW, 7 LB, 8 LW, 9 LUI; 10–15 illegal.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_imm  in  20  immediate field.
  - I-type and S-type use [11:0].
  - SRAI uses [4:0].
  - LUI uses all 20 bits.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer takes the word when `out_valid & out_ready`.
- out_instr  out  32  encoded instruction at the FIFO head.
- out_addr  out  ADDR_W  byte address for `out_instr`.
- err  out  1  sticky illegal-op flag.

## Operation
- Encoding is combinational from the input fields and is written into the FIFO on accept.
  - ADD/XOR: opcode 0110011; funct7 0; funct3 000 for ADD, 100 for XOR.
  - ADDI/ORI: opcode 0010011; funct3 000 for ADDI, 110 for ORI; imm[11:0] goes to [31:20].
  - SRAI: opcode 0010011; funct3 101; [31:25] = 0100000; [24:20] = imm[4:0].
  - SB/SW: opcode 0100011; funct3 000 for SB, 010 for SW; imm[11:5] goes to [31:25], imm[4:0] goes to [11:7].
  - LB/LW: opcode 0000011; funct3 000 for LB, 010 for LW; I-type immediate layout.
  - LUI: opcode 0110111; imm[19:0] goes to [31:12].
  - Fields an op does not use are ignored, and the corresponding bits are encoded as 0.
- Illegal op (10–15):
  - Accepted normally while `in_ready` is high.
  - Not written to the FIFO.
  - `err` is set and stays set until reset.
- `in_ready` = FIFO not full. A full FIFO refuses a push even when a pop happens in the same cycle.
- `out_valid` = FIFO not empty. `out_instr` shows the head entry.
- Address counter:
  - Starts at BASE_ADDR.
  - Adds 4 on every pop.
  - Wraps modulo 2^ADDR_W.
  - `out_addr` equals the counter value.
- Simultaneous push and pop when the FIFO is not full and not empty: both take effect and the count is unchanged.
- `flush`:
  - Empties the FIFO and reloads BASE_ADDR.
  - Any push or pop in the same cycle is discarded.
  - `err` is not cleared.

## Timing
- Reset (asynchronous, immediate):
  - FIFO empty, so `out_valid`=0 and `in_ready`=1.
  - `out_addr`=BASE_ADDR, `out_instr`=0, `err`=0.
- Latency: a word accepted at edge N is shown with `out_valid`=1 after edge N. There is no combinational bypass from input to output.
- Throughput: one word per cycle in steady state when `out_ready` is held high.
- `out_instr` and `out_addr` hold steady while `out_valid & !out_ready`.
- `err` rises on the edge that accepts the illegal command.
- Reset asserted mid-stream drops all buffered words. The first word after reset goes out at BASE_ADDR.

## Test plan
- ADDI x1,x0,5 -> `out_instr`=0x00500093 at `out_addr`=0. Then ADD x3,x1,x2 -> 0x002081B3 at address 4.
- Stream SRAI x4,x1,3; LW x6,4(x1); SW x2,8(x1); LUI x5,0x12345 with `out_ready`=1 -> 0x4030D213, 0x0040A303, 0x0020A423, 0x123452B7 on consecutive cycles at addresses 0, 4, 8, 12.
- `out_ready`=0 while pushing DEPTH+2 commands -> `in_ready` drops after DEPTH accepts. Raise `out_ready` -> words drain in order with no loss or duplicates.
- FIFO full plus a simultaneous push and pop -> the push is refused and the count becomes DEPTH-1. In the half-full case a simultaneous push and pop keeps the count constant.
- `in_op`=12 -> nothing emitted and `err`=1. `err` stays 1 through a following `flush`. Assert `reset_n`=0 with two words buffered -> `out_valid`=0 and `err`=0 immediately.
- ADDR_W=4 and BASE_ADDR=8, pop 3 words -> addresses 8, 12, 0.
